// File: rtl/cle_pkg.sv
// Shared types and helpers for the connected-component labeling engine.
// Holds the FSM state set, the bit order of packed pixels and a width helper.
package cle_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_P1_FETCH,
        S_P1_PIX,
        S_P1_MERGE,
        S_RESOLVE,
        S_P2_RD,
        S_P2_WR,
        S_DONE
    } state_t;

    localparam int PX_PER_BYTE = 8;
    // The leftmost pixel of each ROM byte sits in bit 7.
    localparam logic [2:0] BIT_MSB = 3'd7;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << i) < n) r = i + 1;
        return (r < 1) ? 1 : r;
    endfunction

    function automatic logic [2:0] bit_sel(input logic [2:0] col);
        return BIT_MSB - col;
    endfunction

endpackage

// File: rtl/cle_equiv_table.sv
// Label equivalence table: parent links built during pass 1 and the dense
// final numbering produced by the resolve sweep.
module cle_equiv_table
    import cle_pkg::*;
#(
    parameter int LBL_W   = 8,
    parameter int MAX_LBL = 255
) (
    input  logic             clk,
    input  logic             alloc_en,
    input  logic [LBL_W-1:0] alloc_lbl,
    input  logic [LBL_W-1:0] find_a,
    input  logic [LBL_W-1:0] find_b,
    output logic [LBL_W-1:0] parent_a,
    output logic [LBL_W-1:0] parent_b,
    input  logic             link_en,
    input  logic [LBL_W-1:0] link_child,
    input  logic [LBL_W-1:0] link_root,
    input  logic             res_en,
    input  logic [LBL_W-1:0] res_idx,
    input  logic [LBL_W-1:0] res_val,
    output logic             res_root,
    input  logic [LBL_W-1:0] fin_idx,
    output logic [LBL_W-1:0] fin_q
);

    logic [LBL_W-1:0] parent  [MAX_LBL+1];
    logic [LBL_W-1:0] fin_tab [MAX_LBL+1];

    assign parent_a = parent[find_a];
    assign parent_b = parent[find_b];
    assign res_root = (parent[res_idx] == res_idx);
    assign fin_q    = fin_tab[fin_idx];

    // NOTE: the tables have no reset; every entry is written (alloc/resolve) before it is read.
    // NOTE: clocked state uses <= so all readers in this edge see the pre-edge values.
    always_ff @(posedge clk) begin
        if (alloc_en)
            parent[alloc_lbl] <= alloc_lbl;
        else if (link_en)
            parent[link_child] <= link_root;
        // parent[i] < i for non-roots, so its final entry is already settled.
        if (res_en)
            fin_tab[res_idx] <= res_root ? res_val : fin_tab[parent[res_idx]];
    end

endmodule

// File: rtl/cle_param_engine.sv
// Two-pass connected-component labeling engine: packed binary image in ROM,
// one dense label per pixel written to SRAM, with 4/8-connectivity and overflow flag.
module cle_param_engine
    import cle_pkg::*;
#(
    parameter int IMG_W   = 32,
    parameter int IMG_H   = 32,
    parameter int LBL_W   = 8,
    parameter int MAX_LBL = 255,
    parameter int ROM_AW  = clog2(IMG_W * IMG_H / 8),
    parameter int RAM_AW  = clog2(IMG_W * IMG_H)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              conn8,
    output logic [ROM_AW-1:0] rom_a,
    input  logic [7:0]        rom_q,
    output logic [RAM_AW-1:0] sram_a,
    output logic [LBL_W-1:0]  sram_d,
    input  logic [LBL_W-1:0]  sram_q,
    output logic              sram_wen,
    output logic              busy,
    output logic              finish,
    output logic [LBL_W-1:0]  obj_count,
    output logic              err_ovf
);

    localparam int XW   = clog2(IMG_W);
    localparam int YW   = clog2(IMG_H);
    localparam int NLW  = LBL_W + 1;
    localparam int NPIX = IMG_W * IMG_H;
    localparam logic [NLW-1:0] LBL_LIMIT = NLW'(MAX_LBL + 1);

    state_t            state, ret_state;
    logic [XW-1:0]     x;
    logic [YW-1:0]     y;
    logic [RAM_AW-1:0] pix_addr;
    logic              conn8_r;
    logic [NLW-1:0]    nl, res_i;
    logic [LBL_W-1:0]  w_lbl, nw_lbl, ra, rb, cnt, d_r;
    logic [LBL_W-1:0]  line_buf [IMG_W];
    logic [LBL_W-1:0]  nb_r [4];
    logic [3:0]        pend_r;
    logic              wen_r;

    logic [LBL_W-1:0]  nb [4];
    logic [LBL_W-1:0]  lbl_min, cur_lbl, parent_a, parent_b, fin_q;
    logic [XW-1:0]     ne_x;
    logic [3:0]        pend;
    logic [1:0]        pend_first, pendr_first;
    logic              pix, has_nb, need_new, ovf, last_col, last_pix, byte_end;
    logic              a_root, b_root, res_root;
    state_t            after_pix;

    function automatic logic [1:0] first_set(input logic [3:0] m);
        logic [1:0] r;
        r = '0;
        for (int i = 3; i >= 0; i--)
            if (m[i]) r = 2'(i);
        return r;
    endfunction

    // NOTE: every combinational signal gets a default before any branch, so no latch is inferred.
    always_comb begin
        pix      = rom_q[bit_sel(x[2:0])];
        last_col = (x == XW'(IMG_W - 1));
        last_pix = (pix_addr == RAM_AW'(NPIX - 1));
        byte_end = (x[2:0] == 3'(PX_PER_BYTE - 1));
        ne_x     = last_col ? x : x + 1'b1;
        // Neighbour slots: W, N, NW, NE; row 0 and the right edge read as background.
        nb[0] = w_lbl;
        nb[1] = (y == '0) ? '0 : line_buf[x];
        nb[2] = conn8_r ? nw_lbl : '0;
        nb[3] = (conn8_r && y != '0 && !last_col) ? line_buf[ne_x] : '0;
        lbl_min = '1;
        has_nb  = 1'b0;
        for (int j = 0; j < 4; j++)
            if (nb[j] != '0) begin
                has_nb = 1'b1;
                if (nb[j] < lbl_min) lbl_min = nb[j];
            end
        pend = '0;
        for (int j = 0; j < 4; j++) begin
            pend[j] = pix && nb[j] != '0 && nb[j] != lbl_min;
            for (int k = 0; k < 4; k++)
                if (k < j && nb[k] == nb[j]) pend[j] = 1'b0;
        end
        need_new    = pix && !has_nb;
        ovf         = need_new && (nl == LBL_LIMIT);
        cur_lbl     = !pix ? '0 : (need_new ? nl[LBL_W-1:0] : lbl_min);
        after_pix   = last_pix ? S_RESOLVE : (byte_end ? S_P1_FETCH : S_P1_PIX);
        pend_first  = first_set(pend);
        pendr_first = first_set(pend_r);
        a_root      = (parent_a == ra);
        b_root      = (parent_b == rb);
    end

    cle_equiv_table #(.LBL_W(LBL_W), .MAX_LBL(MAX_LBL)) u_table (
        .clk        (clk),
        .alloc_en   (state == S_P1_PIX && need_new && !ovf),
        .alloc_lbl  (nl[LBL_W-1:0]),
        .find_a     (ra),
        .find_b     (rb),
        .parent_a   (parent_a),
        .parent_b   (parent_b),
        .link_en    (state == S_P1_MERGE && a_root && b_root && ra != rb),
        .link_child ((ra > rb) ? ra : rb),
        .link_root  ((ra > rb) ? rb : ra),
        .res_en     (state == S_RESOLVE && res_i < nl),
        .res_idx    (res_i[LBL_W-1:0]),
        .res_val    (cnt + 1'b1),
        .res_root   (res_root),
        .fin_idx    (sram_q),
        .fin_q      (fin_q)
    );

    // Pass 2 writes in the same cycle the read data arrives, so data/enable bypass the registers there.
    assign sram_d   = (state == S_P2_WR) ? fin_q : d_r;
    assign sram_wen = (state == S_P2_WR) ? (sram_q == '0) : wen_r;

    always_ff @(posedge clk) begin
        if (state == S_P1_PIX && !ovf)
            line_buf[x] <= cur_lbl;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            ret_state <= S_IDLE;
            x         <= '0;
            y         <= '0;
            pix_addr  <= '0;
            conn8_r   <= 1'b0;
            nl        <= '0;
            res_i     <= '0;
            w_lbl     <= '0;
            nw_lbl    <= '0;
            ra        <= '0;
            rb        <= '0;
            cnt       <= '0;
            d_r       <= '0;
            nb_r      <= '{default: '0};
            pend_r    <= '0;
            wen_r     <= 1'b1;
            rom_a     <= '0;
            sram_a    <= '0;
            busy      <= 1'b0;
            finish    <= 1'b0;
            obj_count <= '0;
            err_ovf   <= 1'b0;
        end else begin
            wen_r <= 1'b1;
            case (state)
                S_IDLE, S_DONE: if (start) begin
                    state     <= S_P1_FETCH;
                    busy      <= 1'b1;
                    finish    <= 1'b0;
                    err_ovf   <= 1'b0;
                    obj_count <= '0;
                    conn8_r   <= conn8;
                    x         <= '0;
                    y         <= '0;
                    pix_addr  <= '0;
                    rom_a     <= '0;
                    nl        <= NLW'(1);
                    w_lbl     <= '0;
                    nw_lbl    <= '0;
                    cnt       <= '0;
                end
                S_P1_FETCH: state <= S_P1_PIX;
                S_P1_PIX: if (ovf) begin
                    err_ovf <= 1'b1;
                    busy    <= 1'b0;
                    finish  <= 1'b1;
                    state   <= S_DONE;
                end else begin
                    wen_r  <= 1'b0;
                    sram_a <= pix_addr;
                    d_r    <= cur_lbl;
                    if (need_new) nl <= nl + 1'b1;
                    w_lbl  <= last_col ? '0 : cur_lbl;
                    nw_lbl <= last_col ? '0 : nb[1];
                    x      <= last_col ? '0 : x + 1'b1;
                    if (last_col && y != YW'(IMG_H - 1)) y <= y + 1'b1;
                    if (!last_pix) pix_addr <= pix_addr + 1'b1;
                    if (byte_end && !last_pix) rom_a <= rom_a + 1'b1;
                    res_i  <= NLW'(1);
                    nb_r   <= nb;
                    if (pend != '0) begin
                        state     <= S_P1_MERGE;
                        ret_state <= after_pix;
                        ra        <= lbl_min;
                        rb        <= nb[pend_first];
                        pend_r    <= pend & ~(4'b0001 << pend_first);
                    end else begin
                        state <= after_pix;
                    end
                end
                S_P1_MERGE: if (a_root && b_root) begin
                    if (pend_r != '0) begin
                        ra     <= (ra < rb) ? ra : rb;
                        rb     <= nb_r[pendr_first];
                        pend_r <= pend_r & ~(4'b0001 << pendr_first);
                    end else begin
                        state <= ret_state;
                    end
                end else begin
                    if (!a_root) ra <= parent_a;
                    if (!b_root) rb <= parent_b;
                end
                S_RESOLVE: if (res_i < nl) begin
                    if (res_root) cnt <= cnt + 1'b1;
                    res_i <= res_i + 1'b1;
                end else begin
                    obj_count <= cnt;
                    pix_addr  <= '0;
                    sram_a    <= '0;
                    state     <= S_P2_RD;
                end
                S_P2_RD: state <= S_P2_WR;
                S_P2_WR: if (last_pix) begin
                    busy   <= 1'b0;
                    finish <= 1'b1;
                    state  <= S_DONE;
                end else begin
                    pix_addr <= pix_addr + 1'b1;
                    sram_a   <= pix_addr + 1'b1;
                    state    <= S_P2_RD;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cle_param_engine.sv
// Bench for cle_param_engine: ROM/SRAM models, a flood-fill reference labeler
// and directed images covering connectivity, merging, overflow, reruns and reset.
module tb_cle_param_engine;

    localparam int W = 32;
    localparam int H = 32;
    localparam int NPIX = W * H;
    localparam int MAX_LBL = 255;

    logic       clk, reset_n, start, conn8;
    logic [6:0] rom_a;
    logic [7:0] rom_q;
    logic [9:0] sram_a;
    logic [7:0] sram_d, sram_q;
    logic       sram_wen, busy, finish, err_ovf;
    logic [7:0] obj_count;

    cle_param_engine #(.IMG_W(W), .IMG_H(H), .LBL_W(8), .MAX_LBL(MAX_LBL)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .conn8(conn8),
        .rom_a(rom_a), .rom_q(rom_q),
        .sram_a(sram_a), .sram_d(sram_d), .sram_q(sram_q), .sram_wen(sram_wen),
        .busy(busy), .finish(finish), .obj_count(obj_count), .err_ovf(err_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] rom [NPIX/8];
    logic [7:0] mem [NPIX];
    logic       mem_fill, wr_clr;
    int         wr_cnt;

    always @(posedge clk) rom_q <= rom[rom_a];

    always @(posedge clk) begin
        if (mem_fill) begin
            for (int i = 0; i < NPIX; i++) mem[i] <= 8'hAA;
        end else if (!sram_wen) begin
            mem[sram_a] <= sram_d;
        end
        sram_q <= mem[sram_a];
    end

    always @(posedge clk) begin
        if (wr_clr) wr_cnt <= 0;
        else if (reset_n && !sram_wen) wr_cnt <= wr_cnt + 1;
    end

    int n_cmp = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Image and reference model
    bit img [H][W];
    int m_lab [NPIX];
    int m_cnt, m_fg;
    bit m_ovf;
    int exp_cnt = 0;
    bit exp_ovf = 1'b0;

    task automatic clear_img();
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++) img[y][x] = 1'b0;
    endtask

    task automatic pack_rom();
        for (int p = 0; p < NPIX; p++) rom[p/8][7 - (p % 8)] = img[p / W][p % W];
    endtask

    task automatic compute_model(input bit c8);
        int q[$];
        int prov;
        bit prior;
        prov = 0; m_cnt = 0; m_fg = 0;
        for (int p = 0; p < NPIX; p++) m_lab[p] = 0;
        // Provisional labels are consumed by foreground pixels with no earlier foreground neighbour.
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                if (img[y][x]) begin
                    m_fg++;
                    prior = (x > 0 && img[y][x-1]) || (y > 0 && img[y-1][x]) ||
                            (c8 && y > 0 && x > 0 && img[y-1][x-1]) ||
                            (c8 && y > 0 && x < W-1 && img[y-1][x+1]);
                    if (!prior) prov++;
                end
        for (int p = 0; p < NPIX; p++)
            if (img[p / W][p % W] && m_lab[p] == 0) begin
                m_cnt++;
                m_lab[p] = m_cnt;
                q.push_back(p);
                while (q.size() > 0) begin
                    int cur, cy, cx;
                    cur = q.pop_front();
                    cy = cur / W; cx = cur % W;
                    for (int dy = -1; dy <= 1; dy++)
                        for (int dx = -1; dx <= 1; dx++) begin
                            int ny, nx;
                            ny = cy + dy; nx = cx + dx;
                            if ((dy != 0 || dx != 0) && (c8 || dy == 0 || dx == 0) &&
                                ny >= 0 && ny < H && nx >= 0 && nx < W)
                                if (img[ny][nx] && m_lab[ny*W+nx] == 0) begin
                                    m_lab[ny*W+nx] = m_cnt;
                                    q.push_back(ny*W+nx);
                                end
                        end
                end
            end
        m_ovf = (prov > MAX_LBL);
    endtask

    // Result flags must hold their values for as long as finish is up.
    always @(negedge clk) begin
        if (reset_n) begin
            check("busy_finish_exclusive", busy & finish, 0);
            if (finish) begin
                check("hold_err_ovf", err_ovf, exp_ovf);
                check("hold_obj_count", obj_count, exp_ovf ? 0 : exp_cnt);
            end
        end
    end

    task automatic run(input bit c8, input string tag, input bit poke);
        compute_model(c8);
        pack_rom();
        mem_fill = 1'b1; wr_clr = 1'b1;
        @(negedge clk);
        mem_fill = 1'b0; wr_clr = 1'b0;
        conn8 = c8; start = 1'b1;
        @(negedge clk);
        start = 1'b0; conn8 = ~c8;
        check({tag, "_busy_after_start"}, busy, 1);
        check({tag, "_finish_low"}, finish, 0);
        exp_cnt = m_cnt; exp_ovf = m_ovf;
        if (poke) begin
            repeat (50) @(negedge clk);
            start = 1'b1; conn8 = ~c8;
            @(negedge clk);
            start = 1'b0;
            check({tag, "_start_ignored"}, busy, 1);
        end
        for (int c = 0; c < 20000 && !finish; c++) @(negedge clk);
        check({tag, "_finish"}, finish, 1);
        check({tag, "_busy_done"}, busy, 0);
        check({tag, "_err_ovf"}, err_ovf, m_ovf);
        check({tag, "_obj_count"}, obj_count, m_ovf ? 0 : m_cnt);
        if (!m_ovf) begin
            check({tag, "_write_count"}, wr_cnt, NPIX + m_fg);
            for (int i = 0; i < NPIX; i++)
                check($sformatf("%s_px%0d", tag, i), mem[i], m_lab[i]);
        end
    endtask

    task automatic draw_u(input int xl, input int xr, input int yt, input int yb);
        for (int y = yt; y <= yb; y++) begin
            img[y][xl] = 1'b1;
            img[y][xr] = 1'b1;
        end
        for (int x = xl; x <= xr; x++) img[yb][x] = 1'b1;
    endtask

    task automatic draw_golden();
        clear_img();
        for (int i = 0; i < 4; i++) img[1+i][20+i] = 1'b1;
        for (int i = 0; i < 3; i++) img[5+i][30-i] = 1'b1;
        for (int y = 10; y <= 14; y++)
            for (int x = 5; x <= 9; x++) img[y][x] = 1'b1;
        draw_u(15, 19, 20, 25);
        img[31][31] = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0; start = 1'b0; conn8 = 1'b0; mem_fill = 1'b0; wr_clr = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_finish", finish, 0);
        check("rst_sram_wen", sram_wen, 1);
        check("rst_obj_count", obj_count, 0);
        check("rst_err_ovf", err_ovf, 0);
        check("rst_rom_a", rom_a, 0);
        check("rst_sram_a", sram_a, 0);
        reset_n = 1'b1;
        @(negedge clk);

        clear_img();
        run(1'b0, "empty", 1'b0);
        check("empty_obj_lit", obj_count, 0);

        clear_img();
        img[0][0] = 1'b1; img[1][1] = 1'b1;
        run(1'b0, "diag4", 1'b0);
        check("diag4_obj_lit", obj_count, 2);
        check("diag4_px0_lit", mem[0], 1);
        check("diag4_px33_lit", mem[33], 2);
        run(1'b1, "diag8", 1'b0);
        check("diag8_obj_lit", obj_count, 1);
        check("diag8_px33_lit", mem[33], 1);

        clear_img();
        draw_u(4, 8, 3, 12);
        run(1'b0, "ushape", 1'b0);
        check("ushape_obj_lit", obj_count, 1);
        check("ushape_right_top_lit", mem[3*W+8], 1);
        check("ushape_bottom_lit", mem[12*W+6], 1);

        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++) img[y][x] = ((x + y) % 2 == 0);
        run(1'b0, "checker", 1'b0);
        check("checker_ovf_lit", err_ovf, 1);
        check("checker_obj_lit", obj_count, 0);

        draw_golden();
        run(1'b1, "golden_a", 1'b0);
        check("golden_a_obj_lit", obj_count, 5);
        run(1'b1, "golden_b", 1'b1);
        check("golden_b_obj_lit", obj_count, 5);
        check("golden_diag_lit", mem[1*W+20], 1);
        check("golden_anti_lit", mem[7*W+28], 2);
        check("golden_square_lit", mem[12*W+7], 3);
        check("golden_u_right_lit", mem[20*W+19], 4);
        check("golden_corner_lit", mem[NPIX-1], 5);

        clear_img();
        draw_u(4, 8, 3, 12);
        pack_rom();
        conn8 = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (300) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        check("midrst_busy", busy, 0);
        check("midrst_finish", finish, 0);
        check("midrst_sram_wen", sram_wen, 1);
        check("midrst_obj_count", obj_count, 0);
        reset_n = 1'b1;
        exp_cnt = 0; exp_ovf = 1'b0;
        repeat (2) @(negedge clk);
        check("midrst_idle_busy", busy, 0);
        run(1'b0, "after_rst", 1'b0);
        check("after_rst_obj_lit", obj_count, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
